// File: rtl/maxnet_controller.sv
// Sequencer FSM for the 4-input MaxNet datapath: load, init, multiply, add, check, feed.
// Optional iteration cap with a timeout output when MAXNET_ITER_LIMIT_EN is defined.
module maxnet_controller #(
  parameter int PU_CYCLES = 1,
  parameter int MAX_ITER  = 16,
  parameter int ITER_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              found,
  output logic              main_write,
  output logic              mainRegWrite,
  output logic              actWrite,
  output logic              multWrite,
  output logic              addWrite,
  output logic              s1,
  output logic              s2,
  output logic              s3,
  output logic              s4,
  output logic              busy,
  output logic              done,
`ifdef MAXNET_ITER_LIMIT_EN
  output logic              timeout,
`endif
  output logic [ITER_W-1:0] iter_count
);

  localparam int PH_W = (PU_CYCLES > 1) ? $clog2(PU_CYCLES) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PU_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (PU_CYCLES < 1) begin : g_bad_pu
    $error("maxnet_controller: PU_CYCLES must be >= 1");
  end
  if (MAX_ITER < 1 || MAX_ITER > (1 << ITER_W) - 1) begin : g_bad_iter
    $error("maxnet_controller: MAX_ITER must be >= 1 and fit in ITER_W bits");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_INIT  = 3'd2,
    ST_MULT  = 3'd3,
    ST_ADD   = 3'd4,
    ST_CHECK = 3'd5,
    ST_FEED  = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  state_t            state_reg, state_next;
  logic [PH_W-1:0]   phase_reg;
  logic [ITER_W-1:0] iter_count_reg;
  logic              accept_start;
  logic              phase_last;
  logic              iter_at_cap;

  assign accept_start = (state_reg == ST_IDLE) && start;
  assign phase_last   = (phase_reg == PH_LAST);

`ifdef MAXNET_ITER_LIMIT_EN
  assign iter_at_cap = (iter_count_reg == ITER_W'(MAX_ITER));
`else
  assign iter_at_cap = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_INIT;
      ST_INIT:  state_next = ST_MULT;
      ST_MULT:  if (phase_last) state_next = ST_ADD;
      ST_ADD:   state_next = ST_CHECK;
      ST_CHECK: state_next = (found || iter_at_cap) ? ST_DONE : ST_FEED;
      ST_FEED:  state_next = ST_MULT;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    main_write   = 1'b0;
    mainRegWrite = 1'b0;
    actWrite     = 1'b0;
    multWrite    = 1'b0;
    addWrite     = 1'b0;
    s1           = 1'b0;
    s2           = 1'b0;
    s3           = 1'b0;
    s4           = 1'b0;
    busy         = (state_reg != ST_IDLE);
    done         = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        main_write   = 1'b1;
        mainRegWrite = 1'b1;
      end
      ST_INIT: actWrite  = 1'b1;
      ST_MULT: multWrite = 1'b1;
      ST_ADD:  addWrite  = 1'b1;
      ST_FEED: begin
        actWrite = 1'b1;
        s1       = 1'b1;
        s2       = 1'b1;
        s3       = 1'b1;
        s4       = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Phase counter holds MULT for exactly PU_CYCLES cycles; idles at zero elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg <= '0;
    end else if (state_reg == ST_MULT && !phase_last) begin
      phase_reg <= phase_reg + 1'b1;
    end else begin
      phase_reg <= '0;
    end
  end

  // Counts completed iterations; saturates so a runaway loop cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_count_reg <= '0;
    end else if (accept_start) begin
      iter_count_reg <= '0;
    end else if (state_reg == ST_ADD && iter_count_reg != '1) begin
      iter_count_reg <= iter_count_reg + 1'b1;
    end
  end

  assign iter_count = iter_count_reg;

`ifdef MAXNET_ITER_LIMIT_EN
  logic timeout_reg;

  // found wins over the cap: timeout only when CHECK exits to DONE without found.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_reg <= 1'b0;
    end else if (accept_start) begin
      timeout_reg <= 1'b0;
    end else if (state_reg == ST_CHECK && !found && iter_at_cap) begin
      timeout_reg <= 1'b1;
    end
  end

  assign timeout = timeout_reg;
`endif

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller: two instances (PU_CYCLES=1 and 2) checked cycle by cycle.
// Timeout checks are compiled in when MAXNET_ITER_LIMIT_EN is defined.
module tb_maxnet_controller;

  // obs = {main_write, mainRegWrite, actWrite, multWrite, addWrite, s1, s2, s3, s4, busy, done}
  localparam logic [10:0] E_IDLE  = 11'b00000_0000_00;
  localparam logic [10:0] E_LOAD  = 11'b11000_0000_10;
  localparam logic [10:0] E_INIT  = 11'b00100_0000_10;
  localparam logic [10:0] E_MULT  = 11'b00010_0000_10;
  localparam logic [10:0] E_ADD   = 11'b00001_0000_10;
  localparam logic [10:0] E_CHECK = 11'b00000_0000_10;
  localparam logic [10:0] E_FEED  = 11'b00100_1111_10;
  localparam logic [10:0] E_DONE  = 11'b00000_0000_11;

  logic clk, rst, start, found, sel;
  logic mw_a, mrw_a, aw_a, mlw_a, adw_a, s1_a, s2_a, s3_a, s4_a, busy_a, done_a;
  logic mw_b, mrw_b, aw_b, mlw_b, adw_b, s1_b, s2_b, s3_b, s4_b, busy_b, done_b;
  logic [7:0] ic_a, ic_b, ic;
  logic [10:0] obs_a, obs_b, obs;
  logic start_a, start_b, found_a, found_b;
  int vectors, miscompares, cyc;
  bit noise_on;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign found_a = found & ~sel;
  assign found_b = found & sel;
  assign obs_a = {mw_a, mrw_a, aw_a, mlw_a, adw_a, s1_a, s2_a, s3_a, s4_a, busy_a, done_a};
  assign obs_b = {mw_b, mrw_b, aw_b, mlw_b, adw_b, s1_b, s2_b, s3_b, s4_b, busy_b, done_b};
  assign obs = sel ? obs_b : obs_a;
  assign ic  = sel ? ic_b : ic_a;

`ifdef MAXNET_ITER_LIMIT_EN
  logic to_a, to_b, tmo;
  assign tmo = sel ? to_b : to_a;
`endif

  maxnet_controller #(.PU_CYCLES(1), .MAX_ITER(4), .ITER_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .found(found_a),
    .main_write(mw_a), .mainRegWrite(mrw_a), .actWrite(aw_a), .multWrite(mlw_a),
    .addWrite(adw_a), .s1(s1_a), .s2(s2_a), .s3(s3_a), .s4(s4_a),
    .busy(busy_a), .done(done_a),
`ifdef MAXNET_ITER_LIMIT_EN
    .timeout(to_a),
`endif
    .iter_count(ic_a)
  );

  maxnet_controller #(.PU_CYCLES(2), .MAX_ITER(4), .ITER_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .found(found_b),
    .main_write(mw_b), .mainRegWrite(mrw_b), .actWrite(aw_b), .multWrite(mlw_b),
    .addWrite(adw_b), .s1(s1_b), .s2(s2_b), .s3(s3_b), .s4(s4_b),
    .busy(busy_b), .done(done_b),
`ifdef MAXNET_ITER_LIMIT_EN
    .timeout(to_b),
`endif
    .iter_count(ic_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (noise_on && cyc >= 5) start = 1'b0;
  endtask

  // Runs n iterations from IDLE; found rises in the n-th CHECK when fnd is set.
  task automatic run(input int n, input int pu, input bit hold, input bit noise, input bit fnd);
    noise_on = noise;
    found = 1'b0;
    start = 1'b1;
    cyc = 0;
    step();
    check("load", obs, E_LOAD);
    if (!hold && !noise) start = 1'b0;
    step();
    check("init", obs, E_INIT);
    check("iter_clr", ic, 0);
    for (int it = 1; it <= n; it++) begin
      for (int p = 0; p < pu; p++) begin
        step();
        check("mult", obs, E_MULT);
      end
      step();
      check("add", obs, E_ADD);
      step();
      check("check", obs, E_CHECK);
      check("iter_chk", ic, it);
      found = fnd && (it == n);
      if (it < n) begin
        step();
        found = 1'b0;
        check("feed", obs, E_FEED);
      end
    end
    step();
    found = 1'b0;
    check("done", obs, E_DONE);
    step();
    check("idle", obs, E_IDLE);
    check("iter_final", ic, n);
    noise_on = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    noise_on = 1'b0;
    sel = 1'b0;
    start = 1'b0;
    found = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_a", obs_a, E_IDLE);
    check("rst_b", obs_b, E_IDLE);
    check("rst_ic", ic_a, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single iteration, PU_CYCLES=1: DONE lands in cycle 6.
    sel = 1'b0;
    run(1, 1, 1'b0, 1'b0, 1'b1);

    // Three iterations, PU_CYCLES=2: DONE lands in cycle 17.
    sel = 1'b1;
    run(3, 2, 1'b0, 1'b0, 1'b1);

    // start held during cycles 1..4 of a run is ignored; no second run follows.
    sel = 1'b0;
    run(1, 1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("quiet", obs, E_IDLE);
    end

    // start held across DONE: the second LOAD comes two cycles after done.
    run(2, 1, 1'b1, 1'b0, 1'b1);
    run(1, 1, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of MULT.
    sel = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("pre_rst", obs, E_MULT);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", obs, E_IDLE);
    check("rst_async_ic", ic, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_rst", obs, E_IDLE);

`ifdef MAXNET_ITER_LIMIT_EN
    // Cap reached with found low: timeout raised and held into IDLE.
    sel = 1'b0;
    run(4, 1, 1'b0, 1'b0, 1'b0);
    check("timeout_set", tmo, 1);
    step();
    check("timeout_hold", tmo, 1);
    // found in the 4th CHECK wins over the cap.
    run(4, 1, 1'b0, 1'b0, 1'b1);
    check("timeout_clr", tmo, 0);
`else
    // No cap: 40 iterations with found low never finish.
    sel = 1'b1;
    start = 1'b1;
    cyc = 0;
    step();
    check("ub_load", obs, E_LOAD);
    start = 1'b0;
    step();
    check("ub_init", obs, E_INIT);
    for (int it = 0; it < 40; it++) begin
      step();
      step();
      check("ub_mult", obs, E_MULT);
      step();
      step();
      check("ub_check", obs, E_CHECK);
      step();
      check("ub_feed", obs, E_FEED);
    end
    check("ub_iter", ic, 40);
    rst = 1'b1;
    #1;
    check("ub_rst", obs, E_IDLE);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
